// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT working-store sequencer.
package fft_seq_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [2:0] {IDLE, LOAD, RD, WAIT, WRITE, UNLOAD} seq_state_t;

  // Reverses the low w bits of v (w <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = {<<{v}};
    return r >> (16 - w);
  endfunction

endpackage

// File: rtl/fft_seq_unload.sv
// UNLOAD address/valid pipeline: issues the next read early on a handshake and holds it on stall.
// Build option FFT_SEQ_BITREV_EN selects bit-reversed (natural-order) output addressing.
module fft_seq_unload
  import fft_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              last_fire,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] u;
  logic [ADDR_W-1:0] u_sel;
  logic              fire;

  assign fire      = out_valid & out_ready;
  assign last_fire = fire & (&u);
  // Address of the beat to present next cycle; held when downstream stalls.
  assign u_sel     = (fire && !(&u)) ? u + 1'b1 : u;

`ifdef FFT_SEQ_BITREV_EN
  assign addr = ADDR_W'(bitrev(16'(u_sel), ADDR_W));
`else
  assign addr = u_sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u         <= '0;
      out_valid <= 1'b0;
    end else begin
      u         <= active ? u_sel : '0;
      out_valid <= active & ~last_fire;
    end
  end

endmodule

// File: rtl/fft_m2sram_seq.sv
// Sequencer for the dual-bank working store: LOAD, NUM_STAGES in-place butterfly passes, UNLOAD.
// Build option FFT_SEQ_BITREV_EN (see fft_seq_unload) changes output ordering only.
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | streaming input pairs into both banks
//   RD     | issue read of pair k
//   WAIT   | hold address while the external butterfly computes
//   WRITE  | write butterfly result back to pair k
//   UNLOAD | streaming pairs out under out_ready
module fft_m2sram_seq
  import fft_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_STAGES = 6,
  parameter int BF_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_d0,
  input  logic [DATA_W-1:0] in_d1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q0,
  output logic [DATA_W-1:0] out_q1,
  input  logic [DATA_W-1:0] bf_d0,
  input  logic [DATA_W-1:0] bf_d1,
  output logic [2:0]        stage,
  output logic [ADDR_W-1:0] pair,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [DATA_W-1:0] mem_d0,
  output logic [DATA_W-1:0] mem_d1,
  input  logic [DATA_W-1:0] mem_q0,
  input  logic [DATA_W-1:0] mem_q1
);

  localparam int                WCNT_W     = $clog2(BF_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST_K     = '1;
  localparam logic [2:0]        LAST_STAGE = 3'(NUM_STAGES - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [2:0]        stage_r, stage_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              done_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] unl_addr;
  logic              unl_last;

  fft_seq_unload #(.ADDR_W(ADDR_W)) u_unload (
    .clk       (clk),
    .rst       (rst),
    .active    (state == UNLOAD),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .last_fire (unl_last),
    .addr      (unl_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= '0;
      stage_r <= '0;
      wcnt    <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      k       <= k_nxt;
      stage_r <= stage_nxt;
      wcnt    <= wcnt_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k;
    stage_nxt = stage_r;
    wcnt_nxt  = wcnt;
    done_nxt  = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    addr      = '0;
    mem_d0    = in_d0;
    mem_d1    = in_d1;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          k_nxt     = '0;
          stage_nxt = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        addr     = cnt;
        if (in_valid) begin
          if (cnt == LAST_K) begin
            state_nxt = RD;
            k_nxt     = '0;
            stage_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      RD: begin
        addr      = k;
        wcnt_nxt  = WCNT_W'(BF_LAT);
        state_nxt = WAIT;
      end
      WAIT: begin
        addr = k;
        if (wcnt == '0) state_nxt = WRITE;
        else            wcnt_nxt  = wcnt - 1'b1;
      end
      WRITE: begin
        mem_we = 1'b1;
        addr   = k;
        mem_d0 = bf_d0;
        mem_d1 = bf_d1;
        if (k == LAST_K) begin
          k_nxt = '0;
          if (stage_r == LAST_STAGE) begin
            state_nxt = UNLOAD;
          end else begin
            stage_nxt = stage_r + 3'd1;
            state_nxt = RD;
          end
        end else begin
          k_nxt     = k + 1'b1;
          state_nxt = RD;
        end
      end
      UNLOAD: begin
        addr = unl_addr;
        if (unl_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign stage     = stage_r;
  assign pair      = k;
  assign mem_addr0 = addr;
  assign mem_addr1 = addr;
  assign out_q0    = mem_q0;
  assign out_q1    = mem_q1;

endmodule

// File: tb/tb_fft_m2sram_seq.sv
// Self-checking bench for fft_m2sram_seq with bank and butterfly models; honours FFT_SEQ_BITREV_EN.
`timescale 1ns/1ps
module tb_fft_m2sram_seq;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 64;
  localparam int NUM_STAGES = 6;
  localparam int BF_LAT     = 2;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, out_ready;
  logic              busy, done, in_ready, out_valid, mem_we;
  logic [DATA_W-1:0] in_d0, in_d1, out_q0, out_q1, bf_d0, bf_d1;
  logic [DATA_W-1:0] mem_d0, mem_d1, mem_q0, mem_q1;
  logic [2:0]        stage;
  logic [ADDR_W-1:0] pair, mem_addr0, mem_addr1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];
  logic [DATA_W-1:0] mdl0  [DEPTH];
  logic [DATA_W-1:0] mdl1  [DEPTH];
  logic [DATA_W-1:0] d0a, d0b, d1a, d1b;
  logic [DATA_W-1:0] inc0, inc1;

  typedef struct {
    logic              iv;
    logic              we;
    logic [ADDR_W-1:0] addr;
  } lvec_t;
  lvec_t lv [8];

  fft_m2sram_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_STAGES(NUM_STAGES), .BF_LAT(BF_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_d0(in_d0), .in_d1(in_d1),
    .out_valid(out_valid), .out_ready(out_ready), .out_q0(out_q0), .out_q1(out_q1),
    .bf_d0(bf_d0), .bf_d1(bf_d1), .stage(stage), .pair(pair),
    .mem_we(mem_we), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_d0(mem_d0), .mem_d1(mem_d1), .mem_q0(mem_q0), .mem_q1(mem_q1)
  );

  always #5 clk = ~clk;

  // Two single-port banks with registered read.
  always @(posedge clk) begin
    if (mem_we) begin
      bank0[mem_addr0] <= mem_d0;
      bank1[mem_addr1] <= mem_d1;
    end
    mem_q0 <= bank0[mem_addr0];
    mem_q1 <= bank1[mem_addr1];
  end

  // Butterfly stand-in: adds a constant, BF_LAT = 2 register stages.
  always @(posedge clk) begin
    d0a <= mem_q0; d0b <= d0a;
    d1a <= mem_q1; d1b <= d1a;
  end
  assign bf_d0 = d0b + inc0;
  assign bf_d1 = d1b + inc1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int map_addr(input int j);
    int r;
    r = j;
`ifdef FFT_SEQ_BITREV_EN
    r = 0;
    for (int b = 0; b < ADDR_W; b++)
      if ((j >> b) & 1) r = r | (1 << (ADDR_W - 1 - b));
`endif
    return r;
  endfunction

  task automatic do_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Entered at posedge+1 of first LOAD cycle; leaves at posedge+1 of first RD cycle.
  task automatic load_words(input bit use_tab);
    int   beats, cyc, ti;
    logic v;
    beats = 0; cyc = 0; ti = 0;
    while (beats < DEPTH && cyc < 500) begin
      if (use_tab && ti < 8) v = lv[ti].iv;
      else if (beats >= 24)  v = 1'b1;
      else                   v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_d0 = {$urandom, $urandom};
      in_d1 = {$urandom, $urandom};
      @(negedge clk);
      chk("load_in_ready", in_ready, 1);
      if (use_tab && ti < 8) begin
        chk("tab_we", mem_we, lv[ti].we);
        chk("tab_addr0", mem_addr0, lv[ti].addr);
        chk("tab_addr1", mem_addr1, lv[ti].addr);
        ti++;
      end else begin
        chk("load_we", mem_we, v);
        if (v) chk("load_addr", mem_addr0, beats);
      end
      if (v) begin
        chk("load_d0", mem_d0, in_d0);
        mdl0[beats] = in_d0;
        mdl1[beats] = in_d1;
        beats++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (beats < DEPTH) chk("load_timeout", beats, DEPTH);
  endtask

  // From first RD cycle until the first valid output beat (returns at that negedge).
  task automatic compute;
    int cyc, wr;
    cyc = 0; wr = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (out_valid) break;
      if (mem_we) begin
        chk("wr_stage", stage, wr / DEPTH);
        chk("wr_pair", pair, wr % DEPTH);
        chk("wr_addr1", mem_addr1, wr % DEPTH);
        chk("wr_in_ready", in_ready, 0);
        wr++;
      end
      cyc++;
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 40) == 0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("busy_compute", busy, 1);
    chk("compute_cycles", cyc, NUM_STAGES * DEPTH * (BF_LAT + 3) + 1);
    chk("write_count", wr, NUM_STAGES * DEPTH);
  endtask

  // mode 0: ready always; 1: stall 3 cycles at beat 7; 2: random ready.
  task automatic unload(input int mode);
    int j, cyc, stall, a;
    j = 0; cyc = 0; stall = 0;
    while (j < DEPTH && cyc < 500) begin
      a = map_addr(j);
      if (out_valid) begin
        chk("out_q0", out_q0, mdl0[a] + 64'(NUM_STAGES) * inc0);
        chk("out_q1", out_q1, mdl1[a] + 64'(NUM_STAGES) * inc1);
        if (out_ready) begin
          if (j < DEPTH - 1) chk("unload_next_addr", mem_addr0, map_addr(j + 1));
          j++;
        end else begin
          chk("stall_addr", mem_addr0, a);
        end
      end else begin
        chk("unload_valid_gap", out_valid, 1);
      end
      cyc++;
      @(posedge clk); #1;
      if (mode == 1 && j == 7 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else if (mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    if (mode == 0) chk("unload_cycles", cyc, DEPTH);
    if (mode == 1) chk("unload_stall_cycles", cyc, DEPTH + 3);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_drop", done, 0);
  endtask

  initial begin
    lv[0] = '{1'b1, 1'b1, 5'd0};
    lv[1] = '{1'b0, 1'b0, 5'd1};
    lv[2] = '{1'b1, 1'b1, 5'd1};
    lv[3] = '{1'b1, 1'b1, 5'd2};
    lv[4] = '{1'b0, 1'b0, 5'd3};
    lv[5] = '{1'b0, 1'b0, 5'd3};
    lv[6] = '{1'b1, 1'b1, 5'd3};
    lv[7] = '{1'b1, 1'b1, 5'd4};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_d0 = '0; in_d1 = '0; inc0 = '0; inc1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr0", mem_addr0, 0);
    chk("rst_stage", stage, 0);
    chk("rst_pair", pair, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Run 1: identity butterfly, table-driven load, ready held high.
    out_ready = 1'b1;
    do_start;
    load_words(1'b1);
    chk("rd_busy", busy, 1);
    chk("rd_in_ready", in_ready, 0);
    compute;
    unload(0);

    // Run 2: incrementing butterfly, stall on beat 7.
    inc0 = 64'd1; inc1 = 64'h0000_0001_0000_0001;
    out_ready = 1'b1;
    do_start;
    load_words(1'b0);
    compute;
    unload(1);

    // Run 3: reset during WAIT of stage 3.
    do_start;
    load_words(1'b0);
    begin
      int cyc;
      cyc = 0;
      while (cyc < 2000) begin
        @(negedge clk);
        if (mem_we && stage == 3'd3) break;
        cyc++;
        @(posedge clk); #1;
      end
      chk("reach_stage3", stage, 3);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_addr0", mem_addr0, 0);
    chk("abort_addr1", mem_addr1, 0);
    chk("abort_stage", stage, 0);
    chk("abort_valid", out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Run 4: clean run after abort, random butterfly offset and random ready.
    inc0 = {$urandom, $urandom}; inc1 = {$urandom, $urandom};
    out_ready = 1'b1;
    do_start;
    load_words(1'b0);
    compute;
    unload(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
